// File: rtl/dram_pkg.sv
// dram_pkg: shared types and default timing constants for the DRAM
// command FSM and its timing-signal generator.
//   cmd_state_t : registered state encoding of the command FSM
//   DEF_T_*     : default JEDEC-style timing parameters (cycles)
//   CNT_W       : width of the timing counters
package dram_pkg;

  localparam int CNT_W = 16;

  localparam int DEF_T_RCD        = 14;
  localparam int DEF_T_RD         = 18;
  localparam int DEF_T_WR         = 16;
  localparam int DEF_T_WRW        = 12;
  localparam int DEF_T_RP         = 14;
  localparam int DEF_T_RFC        = 260;
  localparam int DEF_T_REFI       = 7800;
  localparam int DEF_MAX_POSTPONE = 8;

  typedef enum logic [3:0] {
    POWER_UP,
    IDLE,
    ACTIVATE,
    ACTIVATING,
    READ,
    READING,
    WRITE,
    WRITING,
    WAIT_AFTER_WRITE,
    WAITING_AFTER_WRITE,
    PRECHARGE,
    PRECHARGING,
    REFRESH,
    REFRESHING
  } cmd_state_t;

endpackage

// File: rtl/dram_countdown.sv
// dram_countdown: loadable down-counter that saturates at zero.
//   CLK, nRST : clock, synchronous active-low reset
//   load      : load load_val this cycle (overrides dec)
//   load_val  : value to load
//   dec       : decrement by one unless already zero
//   cnt       : current count
//   zero      : cnt == 0
module dram_countdown #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dram_timing_ctrl.sv
// dram_timing_ctrl: timing-signal generator for the DRAM command FSM.
// Loads a countdown on each command state and raises the matching t*_done
// qualifier in the following -ING state; runs the refresh-interval timer
// that raises rf_req and tracks postponed refreshes.
//   CLK, nRST        : clock, synchronous active-low reset
//   cmd_state        : registered state of the command FSM
//   init_done        : power-up initialisation complete
//   tACT_done ...    : done levels, each valid only in its -ING state
//   tREF_done
//   rf_req           : refresh request, held until serviced
//   ref_overdue      : intervals that expired while rf_req was pending
module dram_timing_ctrl
  import dram_pkg::*;
#(
  parameter int T_RCD        = DEF_T_RCD,
  parameter int T_RD         = DEF_T_RD,
  parameter int T_WR         = DEF_T_WR,
  parameter int T_WRW        = DEF_T_WRW,
  parameter int T_RP         = DEF_T_RP,
  parameter int T_RFC        = DEF_T_RFC,
  parameter int T_REFI       = DEF_T_REFI,
  parameter int CNT_W        = dram_pkg::CNT_W,
  parameter int MAX_POSTPONE = DEF_MAX_POSTPONE
) (
  input  logic                                 CLK,
  input  logic                                 nRST,
  input  cmd_state_t                           cmd_state,
  input  logic                                 init_done,
  output logic                                 tACT_done,
  output logic                                 tRD_done,
  output logic                                 tWR_done,
  output logic                                 tWRITE_WAIT_done,
  output logic                                 tPRE_done,
  output logic                                 tREF_done,
  output logic                                 rf_req,
  output logic [$clog2(MAX_POSTPONE+1)-1:0]    ref_overdue
);

  localparam int     OVD_W = $clog2(MAX_POSTPONE + 1);
  localparam longint LIMIT = longint'(1) << CNT_W;

  if (T_RCD < 1 || T_RD < 1 || T_WR < 1 || T_WRW < 1 ||
      T_RP < 1 || T_RFC < 1 || T_REFI < 2) begin : g_bad_min
    $error("dram_timing_ctrl: timing parameter below its minimum");
  end

  if (longint'(T_RCD) >= LIMIT || longint'(T_RD) >= LIMIT ||
      longint'(T_WR) >= LIMIT || longint'(T_WRW) >= LIMIT ||
      longint'(T_RP) >= LIMIT || longint'(T_RFC) >= LIMIT ||
      longint'(T_REFI) >= LIMIT) begin : g_bad_width
    $error("dram_timing_ctrl: timing parameter does not fit CNT_W");
  end

  // ---------------------------------------------------------------
  // Operation countdown
  // ---------------------------------------------------------------
  logic             op_load;
  logic             op_dec;
  logic [CNT_W-1:0] op_load_val;
  logic [CNT_W-1:0] op_cnt;
  logic             op_zero;

  always_comb begin
    op_load     = 1'b1;
    op_load_val = '0;
    case (cmd_state)
      ACTIVATE:         op_load_val = CNT_W'(T_RCD - 1);
      READ:             op_load_val = CNT_W'(T_RD - 1);
      WRITE:            op_load_val = CNT_W'(T_WR - 1);
      WAIT_AFTER_WRITE: op_load_val = CNT_W'(T_WRW - 1);
      PRECHARGE:        op_load_val = CNT_W'(T_RP - 1);
      REFRESH:          op_load_val = CNT_W'(T_RFC - 1);
      default:          op_load     = 1'b0;
    endcase
  end

  // Only one -ING state can be current, so a single shared counter serves
  // every command; decrementing in any -ING state is the matching one.
  assign op_dec = (cmd_state inside {ACTIVATING, READING, WRITING,
                                     WAITING_AFTER_WRITE, PRECHARGING,
                                     REFRESHING});

  dram_countdown #(
    .W (CNT_W)
  ) u_op_cnt (
    .CLK      (CLK),
    .nRST     (nRST),
    .load     (op_load),
    .load_val (op_load_val),
    .dec      (op_dec),
    .cnt      (op_cnt),
    .zero     (op_zero)
  );

  always_comb begin
    tACT_done        = op_zero && (cmd_state == ACTIVATING);
    tRD_done         = op_zero && (cmd_state == READING);
    tWR_done         = op_zero && (cmd_state == WRITING);
    tWRITE_WAIT_done = op_zero && (cmd_state == WAITING_AFTER_WRITE);
    tPRE_done        = op_zero && (cmd_state == PRECHARGING);
    tREF_done        = op_zero && (cmd_state == REFRESHING);
  end

  // ---------------------------------------------------------------
  // Refresh-interval timer
  // ---------------------------------------------------------------
  logic [CNT_W-1:0] ref_cnt;
  logic             timer_run;
  logic             expire;
  logic             service;

  assign timer_run = init_done && (cmd_state != POWER_UP);
  assign expire    = timer_run && (ref_cnt == CNT_W'(T_REFI - 1));
  assign service   = (cmd_state == REFRESH);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ref_cnt     <= '0;
      rf_req      <= 1'b0;
      ref_overdue <= '0;
    end else begin
      // The REFRESH cycle itself is count 0 of the new interval, so the
      // following cycle already holds 1; expiry still wraps to 0.
      if (!timer_run || expire) begin
        ref_cnt <= '0;
      end else if (service) begin
        ref_cnt <= CNT_W'(1);
      end else begin
        ref_cnt <= ref_cnt + CNT_W'(1);
      end

      // Expiry beats a coincident service: the service consumes the
      // interval the expiry would have added, leaving ref_overdue as is.
      if (expire) begin
        rf_req <= 1'b1;
        if (rf_req && !service && (ref_overdue != OVD_W'(MAX_POSTPONE))) begin
          ref_overdue <= ref_overdue + OVD_W'(1);
        end
      end else if (service) begin
        if (ref_overdue != '0) begin
          ref_overdue <= ref_overdue - OVD_W'(1);
        end else begin
          rf_req <= 1'b0;
        end
      end
    end
  end

endmodule
